// File: rtl/output_port_arbiter.sv
// Output-direction arbiter: round-robin over four route-tagged inputs, strips the route
// field, buffers into a first-word-fall-through FIFO. Macro LOCAL_PRIORITY_EN gives port 1 strict priority.
module output_port_arbiter #(
  parameter int modifiedFlitSize = 34,
  parameter int flitWidth        = 32,
  parameter int fifoDepth        = 4,
  parameter int fifoAddrWidth    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [modifiedFlitSize-1:0] inFlit1,
  input  logic [modifiedFlitSize-1:0] inFlit2,
  input  logic [modifiedFlitSize-1:0] inFlit3,
  input  logic [modifiedFlitSize-1:0] inFlit4,
  input  logic [3:0]                  inValid,
  output logic [3:0]                  inGrant,
  output logic [flitWidth-1:0]        outFlit,
  output logic                        outValid,
  input  logic                        portBlock,
  output logic [fifoAddrWidth:0]      fifoCount
);

  localparam int CW = fifoAddrWidth + 1;

  logic [modifiedFlitSize-1:0] flit_in [4];
  logic [flitWidth-1:0]        mem [fifoDepth];
  logic [fifoAddrWidth-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]               fifo_count;
  logic [1:0]                  last_grant;
  logic [flitWidth-1:0]        held_flit;
  logic [1:0]                  win_idx;
  logic [1:0]                  cand;
  logic                        found;
  logic                        push, pop;
  logic [3:0]                  rr_valid;
  logic [7:0]                  unused_route_bits;

  assign flit_in[0] = inFlit1;
  assign flit_in[1] = inFlit2;
  assign flit_in[2] = inFlit3;
  assign flit_in[3] = inFlit4;

  // Route fields are consumed upstream; only the payload is buffered.
  assign unused_route_bits = {inFlit1[modifiedFlitSize-1:flitWidth], inFlit2[modifiedFlitSize-1:flitWidth],
                              inFlit3[modifiedFlitSize-1:flitWidth], inFlit4[modifiedFlitSize-1:flitWidth]};

`ifdef LOCAL_PRIORITY_EN
  assign rr_valid = inValid & 4'b1110;
`else
  assign rr_valid = inValid;
`endif

  // Rotating search starting one past the last winner; index 0 is masked in local-priority mode.
  always_comb begin
    found   = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!found && rr_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
`ifdef LOCAL_PRIORITY_EN
    if (inValid[0]) begin
      found   = 1'b1;
      win_idx = 2'd0;
    end
`endif
  end

  always_comb begin
    inGrant = 4'b0000;
    if (found && (fifo_count < CW'(fifoDepth)))
      inGrant[win_idx] = 1'b1;
  end

  assign push      = |inGrant;
  assign outValid  = (fifo_count != '0);
  assign pop       = outValid && !portBlock;
  assign outFlit   = outValid ? mem[rd_ptr] : held_flit;
  assign fifoCount = fifo_count;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= flit_in[win_idx][flitWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_grant <= 2'd3;
      held_flit  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        held_flit <= mem[rd_ptr];
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
`ifdef LOCAL_PRIORITY_EN
      if (push && win_idx != 2'd0)
        last_grant <= win_idx;
`else
      if (push)
        last_grant <= win_idx;
`endif
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Randomized bench for output_port_arbiter against a queue-based reference model.
module tb_output_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] inFlit1, inFlit2, inFlit3, inFlit4;
  logic [3:0]  inValid;
  logic [3:0]  inGrant;
  logic [31:0] outFlit;
  logic        outValid;
  logic        portBlock;
  logic [2:0]  fifoCount;

  int tests = 0;
  int fails = 0;

  logic [33:0] src_flit [4];
  bit          src_pend [4];
  logic [31:0] model_q [$];
  logic [31:0] model_held;
  int          model_last;

  always #5 clk = ~clk;

  output_port_arbiter dut (
    .clk(clk), .reset(reset),
    .inFlit1(inFlit1), .inFlit2(inFlit2), .inFlit3(inFlit3), .inFlit4(inFlit4),
    .inValid(inValid), .inGrant(inGrant),
    .outFlit(outFlit), .outValid(outValid),
    .portBlock(portBlock), .fifoCount(fifoCount)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner index from the arbitration rules, or -1 when nothing is granted.
  function automatic int model_pick(input logic [3:0] v);
    int idx;
    if (model_q.size() >= 4) return -1;
`ifdef LOCAL_PRIORITY_EN
    if (v[0]) return 0;
    for (int k = 1; k <= 3; k++) begin
      idx = ((model_last - 1 + k) % 3) + 1;
      if (v[idx]) return idx;
    end
`else
    for (int k = 1; k <= 4; k++) begin
      idx = (model_last + k) % 4;
      if (v[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic cycle(input logic [3:0] req_en, input logic pb, input bit do_reset);
    logic [3:0] v;
    int         w;
    logic [3:0] exp_grant;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!src_pend[i] && req_en[i]) begin
        src_flit[i] = {2'($urandom_range(3, 0)), 32'($urandom)};
        src_pend[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) v[i] = src_pend[i] && !do_reset;
    inFlit1 = src_flit[0]; inFlit2 = src_flit[1];
    inFlit3 = src_flit[2]; inFlit4 = src_flit[3];
    inValid   = v;
    portBlock = pb;
    reset     = do_reset;
    #1;
    w = model_pick(v);
    exp_grant = (w >= 0) ? 4'(1 << w) : 4'b0000;
    check_val("inGrant", 64'(inGrant), 64'(exp_grant));
    check_val("outValid", 64'(outValid), 64'(model_q.size() != 0));
    check_val("outFlit", 64'(outFlit), 64'(model_q.size() != 0 ? model_q[0] : model_held));
    check_val("fifoCount", 64'(fifoCount), 64'(model_q.size()));
    check_val("count_max", 64'(fifoCount <= 3'd4), 64'd1);
    @(posedge clk);
    if (do_reset) begin
      model_q.delete();
      model_last = 3;
      model_held = '0;
    end else begin
      if (model_q.size() != 0 && !pb) model_held = model_q.pop_front();
      if (w >= 0) begin
        model_q.push_back(src_flit[w][31:0]);
        src_pend[w] = 1'b0;
`ifdef LOCAL_PRIORITY_EN
        if (w != 0) model_last = w;
`else
        model_last = w;
`endif
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_flit[i] = '0;
      src_pend[i] = 1'b0;
    end
    model_last = 3;
    model_held = '0;
    inFlit1 = '0; inFlit2 = '0; inFlit3 = '0; inFlit4 = '0;
    inValid = '0; portBlock = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (5) cycle(4'b0000, 1'b0, 1'b0);

    src_flit[0] = 34'h2_DEADBEEF;
    src_pend[0] = 1'b1;
    repeat (3) cycle(4'b0000, 1'b0, 1'b0);

    repeat (12) cycle(4'b1111, 1'b0, 1'b0);
    repeat (6) cycle(4'b0000, 1'b0, 1'b0);

    repeat (8) cycle(4'b0110, 1'b1, 1'b0);
    repeat (8) cycle(4'b0110, 1'b0, 1'b0);
    repeat (6) cycle(4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++)
      cycle(4'($urandom), 1'(i % 2 == 0), 1'b0);
    repeat (8) cycle(4'b0000, 1'b0, 1'b0);

    repeat (3) cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (6) cycle(4'b1111, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      cycle(4'($urandom), 1'($urandom_range(3, 0) == 0), 1'($urandom_range(63, 0) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
